// File: rtl/sync_timing_pkg.sv
// Shared timing constants and phase encoding for the composite sync generator.
// PAL values are the defaults; NTSC differs only in lines per field.
package sync_timing_pkg;

    localparam int HPOS_W = 10;
    localparam int LINE_W = 9;

    localparam int PAL_LINE_CLKS   = 228;
    localparam int PAL_HS_CLKS     = 17;
    localparam int PAL_FIELD_LINES = 312;
    localparam int PAL_VS_FIRST    = 0;
    localparam int PAL_VS_LINES    = 3;

    localparam int NTSC_LINE_CLKS   = 228;
    localparam int NTSC_HS_CLKS     = 17;
    localparam int NTSC_FIELD_LINES = 262;
    localparam int NTSC_VS_FIRST    = 0;
    localparam int NTSC_VS_LINES    = 3;

    typedef enum logic [1:0] {
        SYNC_LO = 2'd0,
        ACTIVE  = 2'd1,
        BROAD   = 2'd2,
        SERR    = 2'd3
    } phase_t;

    // Window membership with wrap modulo the field length.
    function automatic logic in_vs_window(input int line, input int field_lines,
                                          input int vs_first, input int vs_lines);
        int offset;
        if (line >= vs_first) begin
            offset = line - vs_first;
        end else begin
            offset = line + field_lines - vs_first;
        end
        return (offset < vs_lines);
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-N up counter with enable, synchronous clear and a wrap strobe
// that is high on the enabled cycle where the count returns to zero.
module mod_counter #(
    parameter int N = 228,
    parameter int W = 10
) (
    input  logic         i_clk,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_count,
    output logic         o_wrap
);

    logic [W-1:0] r_count;
    logic         w_at_max;

    assign w_at_max = (r_count == W'(N - 1));
    assign o_wrap   = i_en & w_at_max;
    assign o_count  = r_count;

    // Count register: clear wins over enable.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_count <= {W{1'b0}};
        end else if (i_en) begin
            r_count <= w_at_max ? {W{1'b0}} : r_count + W'(1);
        end else begin
            r_count <= r_count;
        end
    end

endmodule

// File: rtl/line_sync_generator.sv
// Composite sync transmitter: line/field counters, a per-line phase FSM and
// registered HS_N / VS_N / SYNC / ODD outputs one clock behind the counters.
module line_sync_generator
    import sync_timing_pkg::*;
#(
    parameter int LINE_CLKS   = PAL_LINE_CLKS,
    parameter int HS_CLKS     = PAL_HS_CLKS,
    parameter int FIELD_LINES = PAL_FIELD_LINES,
    parameter int VS_FIRST    = PAL_VS_FIRST,
    parameter int VS_LINES    = PAL_VS_LINES
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    output logic              SYNC,
    output logic              HS_N,
    output logic              VS_N,
    output logic              ODD,
    output logic [LINE_W-1:0] LINE,
    output logic [HPOS_W-1:0] HPOS,
    output logic              SOL
);

    if ((LINE_CLKS < 32) || (LINE_CLKS > 1023) || (HS_CLKS < 1) || (HS_CLKS > LINE_CLKS - 2) ||
        (FIELD_LINES < 8) || (FIELD_LINES > 511) || (VS_FIRST < 0) || (VS_FIRST >= FIELD_LINES) ||
        (VS_LINES < 1) || (VS_LINES > FIELD_LINES - 1)) begin : g_param_check
        $error("line_sync_generator: illegal timing parameter combination");
    end

    localparam logic [HPOS_W-1:0] P_HS_CLKS    = HPOS_W'(HS_CLKS);
    localparam logic [HPOS_W-1:0] P_HS_LAST    = HPOS_W'(HS_CLKS - 1);
    localparam logic [HPOS_W-1:0] P_BROAD_LAST = HPOS_W'(LINE_CLKS - HS_CLKS - 1);
    localparam phase_t P_RST_PHASE =
        in_vs_window(0, FIELD_LINES, VS_FIRST, VS_LINES) ? BROAD : SYNC_LO;

    logic [HPOS_W-1:0] w_hpos;
    logic [LINE_W-1:0] w_line;
    logic [LINE_W-1:0] w_next_line;
    logic              w_hpos_wrap;
    logic              w_line_wrap;
    logic              w_in_win;
    logic              w_next_in_win;
    phase_t            r_phase;
    phase_t            w_phase_next;
    logic              r_hs_n;
    logic              r_vs_n;
    logic              r_sync;
    logic              r_odd;

    mod_counter #(.N(LINE_CLKS), .W(HPOS_W)) u_hpos_cnt (
        .i_clk   (CLK),
        .i_clr   (RST),
        .i_en    (EN),
        .o_count (w_hpos),
        .o_wrap  (w_hpos_wrap)
    );

    mod_counter #(.N(FIELD_LINES), .W(LINE_W)) u_line_cnt (
        .i_clk   (CLK),
        .i_clr   (RST),
        .i_en    (w_hpos_wrap),
        .o_count (w_line),
        .o_wrap  (w_line_wrap)
    );

    // The line wrap strobe is only meaningful when the horizontal counter wraps.
    assign w_next_line   = w_line_wrap ? {LINE_W{1'b0}} : w_line + LINE_W'(1);
    assign w_in_win      = in_vs_window(int'(w_line), FIELD_LINES, VS_FIRST, VS_LINES);
    assign w_next_in_win = in_vs_window(int'(w_next_line), FIELD_LINES, VS_FIRST, VS_LINES);

    // Phase next-state: r_phase always describes the current HPOS.
    always_comb begin
        w_phase_next = r_phase;
        if (w_hpos_wrap) begin
            w_phase_next = w_next_in_win ? BROAD : SYNC_LO;
        end else if (EN) begin
            case (r_phase)
                SYNC_LO: begin
                    if (w_hpos == P_HS_LAST) begin
                        w_phase_next = ACTIVE;
                    end else begin
                        w_phase_next = SYNC_LO;
                    end
                end
                BROAD: begin
                    if (w_hpos == P_BROAD_LAST) begin
                        w_phase_next = SERR;
                    end else begin
                        w_phase_next = BROAD;
                    end
                end
                default: w_phase_next = r_phase;
            endcase
        end else begin
            w_phase_next = r_phase;
        end
    end

    // Phase state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_phase <= P_RST_PHASE;
        end else begin
            r_phase <= w_phase_next;
        end
    end

    // Output registers, one clock behind the counter values they decode.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_hs_n <= 1'b1;
            r_vs_n <= 1'b1;
            r_sync <= 1'b1;
            r_odd  <= 1'b0;
        end else if (EN) begin
            r_hs_n <= (w_hpos >= P_HS_CLKS);
            r_vs_n <= ~w_in_win;
            r_sync <= (r_phase == ACTIVE) || (r_phase == SERR);
            r_odd  <= (w_hpos == {HPOS_W{1'b0}}) ? ~r_odd : r_odd;
        end else begin
            r_hs_n <= r_hs_n;
            r_vs_n <= r_vs_n;
            r_sync <= r_sync;
            r_odd  <= r_odd;
        end
    end

    assign HS_N = r_hs_n;
    assign VS_N = r_vs_n;
    assign SYNC = r_sync;
    assign ODD  = r_odd;
    assign LINE = w_line;
    assign HPOS = w_hpos;
    assign SOL  = EN & ~RST & (w_hpos == {HPOS_W{1'b0}});

endmodule

// File: doc/line_sync_generator.md
Name: line_sync_generator

Overview:
- Generates the active-low composite SYNC stream consumed by the line pulse logic in the PAL conversion path, from the same pixel-rate CLK (3.58 MHz nominal).
- Counts clocks per line and lines per field, then emits three signals: a per-line horizontal pulse, broad vertical-sync pulses on a fixed line window, and a line-parity toggle.
- This is the transmitter end of the SYNC interface. It sits upstream of the line pulse generator and replaces the VDG-derived sync for test and standalone timing.

Parameters:
- LINE_CLKS, 228, CLK cycles per line (legal 32..1023)
- HS_CLKS, 17, horizontal sync low width in CLK cycles (1..LINE_CLKS-2)
- FIELD_LINES, 312, lines per field (legal 8..511)
- VS_FIRST, 0, first line index of the vertical sync window
- VS_LINES, 3, number of vertical sync lines (1..FIELD_LINES-1)

Ports:
- CLK  in  1  system clock; all logic on rising edge
- RST  in  1  synchronous reset, active-high
- EN  in  1  count enable; when low, all counters and outputs hold
- SYNC  out  1  composite sync, active low
- HS_N  out  1  horizontal sync only, active low
- VS_N  out  1  low for every clock of a line inside the vertical sync window
- ODD  out  1  toggles at the start of every line
- LINE  out  9  current line index, 0..FIELD_LINES-1
- HPOS  out  10  current clock index within the line, 0..LINE_CLKS-1
- SOL  out  1  one-CLK strobe when HPOS==0 and EN is high

Behaviour:
- Reset and clock relationship:
  - One clock domain, CLK. Reset is RST: synchronous, active-high.
  - Reset values: HPOS=0, LINE=0, ODD=0, HS_N=1, VS_N=1, SYNC=1, SOL=0.
  - The first EN-high cycle after reset is HPOS=0 of line 0.
- Horizontal counter:
  - HPOS increments on each EN-high clock.
  - At HPOS==LINE_CLKS-1 it wraps to 0, and LINE increments in the same cycle.
  - LINE wraps from FIELD_LINES-1 to 0.
- Outputs are registered and track the counter values one cycle late:
  - HS_N=0 for the clocks where the previous-cycle HPOS was in 0..HS_CLKS-1.
  - VS_N=0 when the line is in the vertical window VS_FIRST..VS_FIRST+VS_LINES-1. The window wraps modulo FIELD_LINES.
  - Latency: 1 CLK from counter value to output.
- SYNC composition:
  - Outside the vertical window, SYNC=HS_N.
  - Inside the window, SYNC is a broad pulse: low for HPOS 0..LINE_CLKS-HS_CLKS-1, high for the final HS_CLKS clocks.
  - This gives the downstream edge detector exactly one falling edge per line in every mode.
- ODD toggles on the registered output cycle that corresponds to HPOS==0.
  - It continues across field wrap with no reset.
  - If FIELD_LINES is odd, parity alternates field to field; the parity is not re-aligned.
- Phase FSM (state encoded from HPOS compare, held in registers):
  - States: SYNC_LO → ACTIVE on HPOS==HS_CLKS-1 (normal lines).
  - States: BROAD → SERR on HPOS==LINE_CLKS-HS_CLKS-1 (vertical lines).
  - Any state → SYNC_LO or BROAD on wrap, selected by the next line's window membership.
- EN low: counters, FSM and all outputs hold, and SOL=0. Resuming continues the sequence exactly, with no skipped or repeated clock.
- RST asserted mid-line or mid-vsync: on the next edge every output takes its reset value. No partial pulse is extended.
- Simultaneous RST and EN: RST wins.
- Invalid parameter combinations are caught by an elaboration-time check. There is no runtime clamping.

Decomposition:
- Shared package (sync_timing_pkg):
  - PAL defaults: 228/17/312/0/3.
  - NTSC alternatives: 228/17/262/0/3.
  - Width constants: HPOS_W=10, LINE_W=9.
  - Phase state encoding: SYNC_LO, ACTIVE, BROAD, SERR.
- One sub-module, mod_counter: a parameterised modulo-N counter with enable, synchronous clear and wrap strobe. It is instantiated twice, once for HPOS and once for LINE, with the HPOS wrap strobe chained as the LINE enable.

Test Plan:
- RST held 3 clocks then released with EN=1, defaults → first HS_N low for 17 clocks starting 1 CLK after release; next HS_N falling edge exactly 228 clocks later.
- Run 2 fields → VS_N low for 3×228=684 consecutive clocks per field. Falling edges of VS_N are 312×228=71136 clocks apart. SYNC inside the window is low 211 clocks and high 17 clocks per line.
- Check one falling SYNC edge per line → exactly 312 falling edges per field. ODD toggles 312 times per field and has the same value at the start of consecutive fields.
- EN dropped for 50 clocks at HPOS=10 → all outputs frozen. Sequence resumes at HPOS=11 and the line length measured in EN-high clocks is still 228.
- RST pulsed at LINE=1, HPOS=100 (inside the broad pulse) → SYNC=1, VS_N=1, LINE=0, HPOS=0 on the next edge. A fresh line-0 broad pulse starts after release.
- Override LINE_CLKS=32, HS_CLKS=4, FIELD_LINES=8, VS_FIRST=6, VS_LINES=3 → vertical window wraps across lines 6,7,0. LINE outputs 0..7 repeatedly and HPOS never exceeds 31.
